instr_rom_loader: RTL

Instruction memory with a UART boot-loader front end. It sits directly upstream of instruction fetch: fetch drives the word address, and this block returns the instruction word one clock later. In load mode it holds the CPU and receives a length-prefixed byte stream from the UART receiver. It assembles the bytes into 32-bit words, writes them from address 0, then restarts the CPU with a one-cycle reset pulse.

---
 rtl/instr_rom_loader_pkg.sv | 15 +
 rtl/instr_ram.sv | 23 ++
 rtl/instr_rom_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/instr_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM with UART boot loader.
package instr_rom_loader_pkg;

  localparam int          ADDR_W_DEFAULT = 14;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } load_state_e;

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port DEPTH x 32 RAM: one synchronous write port, one synchronous read port.
module instr_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_rom_loader.sv
// Instruction memory with a UART boot loader: holds the CPU, loads a length-prefixed
// big-endian word stream from address 0, then restarts the CPU with a one-cycle pulse.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; every strobe seen in
// LEN_HI, LEN_LO or DATA while load_mode is high consumes rx_data, otherwise it is dropped.
module instr_rom_loader
  import instr_rom_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_adr_i,
  output logic [31:0]       Instruction_o,
  input  logic              load_mode,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cpu_hold,
  output logic              cpu_rst_o,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_written,
  output logic [2:0]        dbg_state
);

  localparam int          DEPTH   = 2**ADDR_W;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  load_state_e state, next_state;

  logic [15:0] len_q;
  logic [15:0] w_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;       // first three bytes of the word being assembled
  logic        done_q, err_q, hold_q, rst_q, mask_q;
  logic [15:0] ww_q;

  logic        take_byte;
  logic        word_last;
  logic        word_fire;
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign word_last = ({1'b0, w_q} + 17'd1) == {1'b0, len_q};
  assign word_fire = take_byte && (state == ST_DATA) && (byte_cnt_q == 2'd3);
  assign ram_we    = word_fire && ({1'b0, w_q} < DEPTH_L);

  always_comb begin
    next_state = state;
    take_byte  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_mode) next_state = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (!load_mode) begin
          next_state = ST_IDLE;
        end else if (rx_valid) begin
          take_byte  = 1'b1;
          next_state = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (!load_mode) begin
          next_state = ST_IDLE;
        end else if (rx_valid) begin
          take_byte  = 1'b1;
          next_state = ({len_q[15:8], rx_data} == 16'd0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (!load_mode) begin
          next_state = ST_IDLE;
        end else if (rx_valid) begin
          take_byte = 1'b1;
          if (byte_cnt_q == 2'd3 && word_last) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!load_mode) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      w_q        <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ww_q       <= '0;
      hold_q     <= 1'b0;
      rst_q      <= 1'b0;
      mask_q     <= 1'b1;
    end else begin
      state  <= next_state;
      hold_q <= (next_state != ST_IDLE);
      mask_q <= (next_state != ST_IDLE);
      rst_q  <= (state != ST_IDLE) && (next_state == ST_IDLE);

      if (state == ST_IDLE && next_state == ST_LEN_HI) begin
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        ww_q       <= '0;
        w_q        <= '0;
        byte_cnt_q <= '0;
      end

      if (take_byte) begin
        case (state)
          ST_LEN_HI: len_q[15:8] <= rx_data;
          ST_LEN_LO: len_q[7:0]  <= rx_data;
          ST_DATA: begin
            asm_q      <= {asm_q[15:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) w_q <= w_q + 16'd1;
          end
          default: ;
        endcase
      end

      if (ram_we) ww_q <= ww_q + 16'd1;

      // Only a DATA-phase finish can have overflowed; a zero length enters DONE from LEN_LO.
      if (state != ST_DONE && next_state == ST_DONE) begin
        done_q <= 1'b1;
        err_q  <= (state == ST_DATA) && ({1'b0, len_q} > DEPTH_L);
      end

      if ((state == ST_LEN_HI || state == ST_LEN_LO || state == ST_DATA) &&
          next_state == ST_IDLE) begin
        done_q <= 1'b0;
        err_q  <= 1'b1;
      end
    end
  end

  instr_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (w_q[ADDR_W-1:0]),
    .wdata ({asm_q, rx_data}),
    .raddr (rom_adr_i),
    .rdata (ram_rdata)
  );

  assign Instruction_o = mask_q ? NOP_WORD : ram_rdata;
  assign cpu_hold      = hold_q;
  assign cpu_rst_o     = rst_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_written = ww_q;
  assign dbg_state     = state;

endmodule
